picorv32_pcpi_dispatch: RTL and testbench
=========================================

Name: picorv32_pcpi_dispatch

Overview:
Sits between the core's PCPI master port and up to NUM_SLV PCPI coprocessors (fast multiplier on slot 0, divider on slot 1). It broadcasts each core request to all slots and captures the first response. It returns that response to the core as a registered, single-cycle ready pulse. If no slot claims the instruction within TIMEOUT_CYCLES, it raises a timeout so the core can take the illegal-instruction trap.

Parameters:
NUM_SLV, 2, number of coprocessor slots (1..4); lower index wins on simultaneous ready.
TIMEOUT_CYCLES, 16, unclaimed-ISSUE cycles before timeout (2..255).

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
pcpi_valid  in  1  core request valid; held until pcpi_ready or pcpi_timeout
pcpi_insn  in  32  instruction word
pcpi_rs1  in  32  operand 1
pcpi_rs2  in  32  operand 2
pcpi_wr  out  1  write rd back; qualified by pcpi_ready
pcpi_rd  out  32  result
pcpi_wait  out  1  some slot has claimed the instruction and is still busy
pcpi_ready  out  1  one-cycle completion pulse
pcpi_timeout  out  1  one-cycle unclaimed pulse
slv_valid  out  NUM_SLV  per-slot request valid
slv_insn  out  32  registered copy of pcpi_insn
slv_rs1  out  32  registered copy of pcpi_rs1
slv_rs2  out  32  registered copy of pcpi_rs2
slv_wr  in  NUM_SLV  per-slot write flag
slv_rd  in  32*NUM_SLV  per-slot result; slot k occupies bits [32k+31:32k]
slv_wait  in  NUM_SLV  per-slot busy
slv_ready  in  NUM_SLV  per-slot done

Behaviour:
- Reset:
  - state=IDLE.
  - pcpi_ready, pcpi_wr, pcpi_timeout, pcpi_wait, slv_valid are all 0.
  - pcpi_rd, slv_insn, slv_rs1, slv_rs2 are all 0.
  - timeout counter is 0.
- Reset mid-operation aborts any transaction. No ready or timeout pulse is emitted.
- States: IDLE, ISSUE, RESP, DRAIN.
- IDLE:
  - On pcpi_valid, latch insn, rs1 and rs2 into slv_insn, slv_rs1 and slv_rs2.
  - Clear the counter and go to ISSUE.
- ISSUE:
  - slv_valid = all ones (registered: high exactly in ISSUE cycles).
  - pcpi_wait = |slv_wait. This is combinational, gated by state==ISSUE.
  - Any slv_ready: select the lowest set index k. Register pcpi_rd=slv_rd[k], pcpi_wr=slv_wr[k], pcpi_ready=1, then go to RESP.
  - Else if any slv_wait: clear the counter.
  - Else if counter==TIMEOUT_CYCLES-1: register pcpi_timeout=1 and go to RESP.
  - Else: counter increments.
  - pcpi_valid low in ISSUE (abort): go to DRAIN with no pulse. slv_ready in that same cycle is ignored.
- RESP:
  - pcpi_ready or pcpi_timeout is high for exactly this one cycle, and pcpi_rd/pcpi_wr are valid.
  - slv_valid=0. Next state is DRAIN.
- DRAIN:
  - slv_valid=0 for one cycle, so a slot that re-arms on valid (the multiplier) sees a gap.
  - Next state is IDLE. pcpi_valid is not sampled.
- pcpi_ready and pcpi_timeout are never high together.
- Back-to-back requests have a minimum period of 4 cycles: IDLE → ISSUE → RESP → DRAIN.
- Latency: core valid seen at cycle 0. slv_valid high from cycle 1. A slot ready at cycle n gives pcpi_ready at n+1.
- pcpi_rd holds its last value outside RESP. pcpi_wr is 0 outside RESP.
- Responses arriving outside ISSUE are ignored.

Test Plan:
1. NUM_SLV=2. Slot0 models the fast multiplier (ready 2 cycles after valid, wr=1). rs1=7, rs2=6, MUL insn. Valid at cycle 0 → slv_valid cycles 1-2, slot0 ready cycle 3 → pcpi_ready=1, pcpi_wr=1, pcpi_rd=42 in cycle 4 only; slv_valid=0 in cycles 4-5.
2. Slot0 and slot1 both assert ready in the same cycle with rd 0x11111111 and 0x22222222 → pcpi_rd=0x11111111, single ready pulse.
3. TIMEOUT_CYCLES=8, no slot responds, valid at cycle 0 → pcpi_timeout=1 in cycle 9 only, pcpi_ready never asserted, state IDLE at cycle 11.
4. Slot1 asserts wait for 100 cycles, then ready with rd=0xDEADBEEF → no timeout, pcpi_wait=1 throughout, pcpi_ready with rd=0xDEADBEEF one cycle after slot ready.
5. Core drops pcpi_valid in the 3rd ISSUE cycle while slot0 asserts ready that cycle → no pcpi_ready/pcpi_timeout, slv_valid=0 next cycle, IDLE two cycles later.
6. reset asserted during ISSUE with slot0 ready next cycle → all outputs 0 the cycle after reset, no ready pulse; a new request after reset completes normally with rd=rs1*rs2.

Source files
------------

// File: rtl/picorv32_pcpi_dispatch.sv
// rtl/picorv32_pcpi_dispatch.sv - PCPI request broadcast to coprocessor slots with first-response capture and timeout
module picorv32_pcpi_dispatch #(
   parameter int NUM_SLV        = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pcpi_valid,
   input  logic [31:0]            pcpi_insn,
   input  logic [31:0]            pcpi_rs1,
   input  logic [31:0]            pcpi_rs2,
   output logic                   pcpi_wr,
   output logic [31:0]            pcpi_rd,
   output logic                   pcpi_wait,
   output logic                   pcpi_ready,
   output logic                   pcpi_timeout,
   output logic [NUM_SLV-1:0]     slv_valid,
   output logic [31:0]            slv_insn,
   output logic [31:0]            slv_rs1,
   output logic [31:0]            slv_rs2,
   input  logic [NUM_SLV-1:0]     slv_wr,
   input  logic [32*NUM_SLV-1:0]  slv_rd,
   input  logic [NUM_SLV-1:0]     slv_wait,
   input  logic [NUM_SLV-1:0]     slv_ready
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP, DRAIN} state_t;

   state_t      state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic        load, ready_nx, timeout_nx;
   logic        sel_wr;
   logic [31:0] sel_rd;

   // Walk from the top slot down so the lowest ready index is the one left selected.
   always_comb begin
      sel_wr = 1'b0;
      sel_rd = '0;
      for (int k = NUM_SLV - 1; k >= 0; k--) begin
         if (slv_ready[k]) begin
            sel_wr = slv_wr[k];
            sel_rd = slv_rd[32*k +: 32];
         end
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      load       = 1'b0;
      ready_nx   = 1'b0;
      timeout_nx = 1'b0;
      case (state)
         IDLE: begin
            if (pcpi_valid) begin
               load     = 1'b1;
               cnt_nx   = '0;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            // A core abort takes priority over any response arriving in the same cycle.
            if (!pcpi_valid) begin
               state_nx = DRAIN;
            end else if (|slv_ready) begin
               ready_nx = 1'b1;
               state_nx = RESP;
            end else if (|slv_wait) begin
               cnt_nx = '0;
            end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
               timeout_nx = 1'b1;
               state_nx   = RESP;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         RESP:    state_nx = DRAIN;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         pcpi_ready   <= 1'b0;
         pcpi_timeout <= 1'b0;
         pcpi_wr      <= 1'b0;
         pcpi_rd      <= '0;
         slv_valid    <= '0;
         slv_insn     <= '0;
         slv_rs1      <= '0;
         slv_rs2      <= '0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         pcpi_ready   <= ready_nx;
         pcpi_timeout <= timeout_nx;
         pcpi_wr      <= ready_nx & sel_wr;
         slv_valid    <= {NUM_SLV{state_nx == ISSUE}};
         if (ready_nx) pcpi_rd <= sel_rd;
         if (load) begin
            slv_insn <= pcpi_insn;
            slv_rs1  <= pcpi_rs1;
            slv_rs2  <= pcpi_rs2;
         end
      end
   end

   assign pcpi_wait = (state == ISSUE) && (|slv_wait);

endmodule

// File: tb/tb_picorv32_pcpi_dispatch.sv
// tb/tb_picorv32_pcpi_dispatch.sv - directed scoreboard bench for picorv32_pcpi_dispatch
module tb_picorv32_pcpi_dispatch;

   logic        clk = 1'b0;
   logic        reset;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
   logic        pcpi_wr, pcpi_wait, pcpi_ready, pcpi_timeout;
   logic [31:0] pcpi_rd;
   logic [1:0]  slv_valid;
   logic [31:0] slv_insn, slv_rs1, slv_rs2;
   logic [1:0]  slv_wr, slv_wait, slv_ready;
   logic [63:0] slv_rd;

   typedef struct packed {
      logic        to;
      logic        wr;
      logic [31:0] rd;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   localparam logic [31:0] MUL_INSN = 32'h02C5_8533;

   picorv32_pcpi_dispatch #(.NUM_SLV(2), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
      .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait),
      .pcpi_ready(pcpi_ready), .pcpi_timeout(pcpi_timeout),
      .slv_valid(slv_valid), .slv_insn(slv_insn), .slv_rs1(slv_rs1), .slv_rs2(slv_rs2),
      .slv_wr(slv_wr), .slv_rd(slv_rd), .slv_wait(slv_wait), .slv_ready(slv_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Every completion or timeout pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && (pcpi_ready || pcpi_timeout)) begin
         exp_t e;
         checks++;
         assert (!(pcpi_ready && pcpi_timeout)) else begin
            failures++;
            $error("FAIL sb_both observed=%b%b expected=not both", pcpi_ready, pcpi_timeout);
         end
         checks++;
         if (q.size() == 0) begin
            failures++;
            $error("FAIL sb_unexpected observed=ready%b/timeout%b expected=no pulse", pcpi_ready, pcpi_timeout);
         end else begin
            e = q.pop_front();
            assert (pcpi_timeout === e.to && pcpi_ready === !e.to) else begin
               failures++;
               $error("FAIL sb_kind observed=timeout%b expected=timeout%b", pcpi_timeout, e.to);
            end
            if (!e.to) begin
               checks++;
               assert (pcpi_rd === e.rd && pcpi_wr === e.wr) else begin
                  failures++;
                  $error("FAIL sb_data observed=%h/%b expected=%h/%b", pcpi_rd, pcpi_wr, e.rd, e.wr);
               end
            end
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"},   {31'd0, pcpi_ready},   32'd0);
      chk({tag, "_wr"},      {31'd0, pcpi_wr},      32'd0);
      chk({tag, "_timeout"}, {31'd0, pcpi_timeout}, 32'd0);
      chk({tag, "_wait"},    {31'd0, pcpi_wait},    32'd0);
      chk({tag, "_svalid"},  {30'd0, slv_valid},    32'd0);
      chk({tag, "_rd"},      pcpi_rd,               32'd0);
      chk({tag, "_insn"},    slv_insn,              32'd0);
      chk({tag, "_rs1"},     slv_rs1,               32'd0);
      chk({tag, "_rs2"},     slv_rs2,               32'd0);
   endtask

   initial begin
      reset = 1'b1; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
      slv_wr = '0; slv_rd = '0; slv_wait = '0; slv_ready = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk_all_zero("reset");

      // Multiply 7*6 on slot 0, ready two cycles after valid
      pcpi_valid = 1'b1; pcpi_insn = MUL_INSN; pcpi_rs1 = 32'd7; pcpi_rs2 = 32'd6;
      q.push_back('{to: 1'b0, wr: 1'b1, rd: 32'd42});
      tick();
      chk("t1_svalid_c1", {30'd0, slv_valid}, 32'd3);
      chk("t1_insn", slv_insn, MUL_INSN);
      chk("t1_rs1", slv_rs1, 32'd7);
      chk("t1_rs2", slv_rs2, 32'd6);
      tick();
      chk("t1_svalid_c2", {30'd0, slv_valid}, 32'd3);
      tick();
      slv_ready = 2'b01; slv_wr = 2'b01; slv_rd[31:0] = slv_rs1 * slv_rs2;
      chk("t1_noready_c3", {31'd0, pcpi_ready}, 32'd0);
      tick();
      slv_ready = '0; slv_wr = '0;
      chk("t1_ready_c4", {31'd0, pcpi_ready}, 32'd1);
      chk("t1_wr_c4", {31'd0, pcpi_wr}, 32'd1);
      chk("t1_rd_c4", pcpi_rd, 32'd42);
      chk("t1_svalid_c4", {30'd0, slv_valid}, 32'd0);
      pcpi_valid = 1'b0;
      tick();
      chk("t1_ready_c5", {31'd0, pcpi_ready}, 32'd0);
      chk("t1_wr_c5", {31'd0, pcpi_wr}, 32'd0);
      chk("t1_svalid_c5", {30'd0, slv_valid}, 32'd0);
      chk("t1_rd_hold", pcpi_rd, 32'd42);
      tick();

      // Simultaneous ready: slot 0 wins
      pcpi_valid = 1'b1;
      q.push_back('{to: 1'b0, wr: 1'b1, rd: 32'h1111_1111});
      tick();
      slv_ready = 2'b11; slv_wr = 2'b11; slv_rd = {32'h2222_2222, 32'h1111_1111};
      tick();
      slv_ready = '0; slv_wr = '0;
      chk("t2_ready", {31'd0, pcpi_ready}, 32'd1);
      chk("t2_rd", pcpi_rd, 32'h1111_1111);
      pcpi_valid = 1'b0;
      tick();
      chk("t2_single_pulse", {31'd0, pcpi_ready}, 32'd0);
      tick();

      // Unclaimed request: timeout pulse in cycle 9
      pcpi_valid = 1'b1;
      q.push_back('{to: 1'b1, wr: 1'b0, rd: 32'd0});
      repeat (8) tick();
      chk("t3_no_timeout_c8", {31'd0, pcpi_timeout}, 32'd0);
      tick();
      chk("t3_timeout_c9", {31'd0, pcpi_timeout}, 32'd1);
      chk("t3_noready_c9", {31'd0, pcpi_ready}, 32'd0);
      chk("t3_wr_c9", {31'd0, pcpi_wr}, 32'd0);
      pcpi_valid = 1'b0;
      tick();
      chk("t3_timeout_c10", {31'd0, pcpi_timeout}, 32'd0);
      pcpi_valid = 1'b1;
      tick();
      chk("t3_drain_ignores_valid", {30'd0, slv_valid}, 32'd0);
      tick();
      chk("t3_idle_accepts", {30'd0, slv_valid}, 32'd3);

      // Long wait on slot 1 holds off the timeout
      slv_wait = 2'b10;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("t4_wait", {31'd0, pcpi_wait}, 32'd1);
      end
      slv_ready = 2'b10; slv_wr = 2'b10; slv_rd = {32'hDEAD_BEEF, 32'h0};
      q.push_back('{to: 1'b0, wr: 1'b1, rd: 32'hDEAD_BEEF});
      tick();
      slv_ready = '0; slv_wr = '0; slv_wait = '0;
      chk("t4_ready", {31'd0, pcpi_ready}, 32'd1);
      chk("t4_rd", pcpi_rd, 32'hDEAD_BEEF);
      chk("t4_wait_outside_issue", {31'd0, pcpi_wait}, 32'd0);
      pcpi_valid = 1'b0;
      repeat (2) tick();

      // Abort in the third ISSUE cycle while slot 0 is ready
      pcpi_valid = 1'b1;
      repeat (3) tick();
      pcpi_valid = 1'b0; slv_ready = 2'b01; slv_wr = 2'b01; slv_rd = {32'h0, 32'h0000_0055};
      tick();
      slv_ready = '0; slv_wr = '0;
      chk("t5_noready", {31'd0, pcpi_ready}, 32'd0);
      chk("t5_notimeout", {31'd0, pcpi_timeout}, 32'd0);
      chk("t5_svalid", {30'd0, slv_valid}, 32'd0);
      pcpi_valid = 1'b1;
      tick();
      chk("t5_still_drain", {30'd0, slv_valid}, 32'd0);
      tick();
      chk("t5_idle_accepts", {30'd0, slv_valid}, 32'd3);

      // Reset during ISSUE, slot 0 ready the next cycle
      reset = 1'b1;
      tick();
      reset = 1'b0; pcpi_valid = 1'b0; slv_ready = 2'b01; slv_wr = 2'b01;
      chk_all_zero("t6_after_reset");
      tick();
      slv_ready = '0; slv_wr = '0;
      chk("t6_noready", {31'd0, pcpi_ready}, 32'd0);
      pcpi_valid = 1'b1; pcpi_rs1 = 32'd1234; pcpi_rs2 = 32'd5678;
      q.push_back('{to: 1'b0, wr: 1'b1, rd: 32'd7006652});
      repeat (2) tick();
      slv_ready = 2'b01; slv_wr = 2'b01; slv_rd[31:0] = slv_rs1 * slv_rs2;
      tick();
      slv_ready = '0; slv_wr = '0;
      chk("t6_ready", {31'd0, pcpi_ready}, 32'd1);
      chk("t6_rd", pcpi_rd, 32'd7006652);
      pcpi_valid = 1'b0;
      repeat (3) tick();

      chk("sb_empty", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
